// File: rtl/uart_fifo_if.sv
// Register bus between a host and uart_fifo: byte-offset write/read with lane enables.
interface uart_fifo_if;
   logic [7:0]  waddr_i;
   logic [31:0] data_i;
   logic [3:0]  sel_i;
   logic        we_i;
   logic [7:0]  raddr_i;
   logic        rd_i;
   logic [31:0] data_o;

   modport master (
      output waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
      input  data_o
   );

   modport slave (
      input  waddr_i, data_i, sel_i, we_i, raddr_i, rd_i,
      output data_o
   );
endinterface

// File: rtl/uart_fifo.sv
// UART with register interface, programmable baud divider, parity/stop options
// and TX/RX byte FIFOs.
module uart_fifo #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD_DEF   = 115200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_fifo_if.slave  bus,
   output logic        tx_pin,
   input  logic        rx_pin
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0]   DIV_RST  = 16'(CLK_HZ / BAUD_DEF - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_BAUD   = 8'h08;
   localparam logic [7:0] ADDR_TXDATA = 8'h0C;
   localparam logic [7:0] ADDR_RXDATA = 8'h10;
   localparam logic [7:0] ADDR_LEVEL  = 8'h14;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [4:0]  ctrl;
   logic [15:0] div;
   logic        overrun, par_err, frm_err;

   logic tx_en, rx_en, par_en, par_odd, stop2;
   assign tx_en   = ctrl[0];
   assign rx_en   = ctrl[1];
   assign par_en  = ctrl[2];
   assign par_odd = ctrl[3];
   assign stop2   = ctrl[4];

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wp, tx_rp;
   logic [CW-1:0] tx_cnt;
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wp, rx_rp;
   logic [CW-1:0] rx_cnt;

   state_t      tx_state, rx_state;
   logic [15:0] tx_bcnt, rx_bcnt;
   logic [2:0]  tx_bit, rx_bit;
   logic [7:0]  tx_data, rx_shift;
   logic        tx_stop2nd, rx_par;
   logic        rx_s1, rx_s2, rx_prev;

   logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;
   logic tx_push_c, tx_pop_c, rx_push_c, rx_pop_c, rx_done_c, par_bad_c, w1c_c;
   logic [16:0] div_p1_c;
   logic [15:0] half_c, half_m1_c;
   logic [31:0] rdata_c;

   logic unused_bits;
   assign unused_bits = ^{bus.data_i[31:16], bus.sel_i[3:2]};

   assign tx_empty = (tx_cnt == '0);
   assign tx_full  = (tx_cnt == FULL_CNT);
   assign rx_empty = (rx_cnt == '0);
   assign rx_full  = (rx_cnt == FULL_CNT);
   assign tx_busy  = (tx_state != S_IDLE) || !tx_empty;

   assign tx_push_c = bus.we_i && bus.sel_i[0] && (bus.waddr_i == ADDR_TXDATA) && !tx_full;
   assign tx_pop_c  = (tx_state == S_IDLE) && tx_en && !tx_empty;
   assign rx_pop_c  = bus.rd_i && (bus.raddr_i == ADDR_RXDATA) && !rx_empty;
   assign rx_done_c = rx_en && (rx_state == S_STOP) && (rx_bcnt == 16'd0);
   assign rx_push_c = rx_done_c && !rx_full;
   assign par_bad_c = par_en && (rx_par != (^rx_shift ^ par_odd));
   assign w1c_c     = bus.we_i && bus.sel_i[0] && (bus.waddr_i == ADDR_STATUS);

   // Mid-bit sample point: (div+1)/2 cycles after the detected edge
   assign div_p1_c  = 17'(div) + 17'd1;
   assign half_c    = div_p1_c[16:1];
   assign half_m1_c = (half_c == 16'd0) ? 16'd0 : half_c - 16'd1;

   // Control and baud registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl <= '0;
         div  <= DIV_RST;
      end else if (bus.we_i) begin
         if (bus.waddr_i == ADDR_CTRL && bus.sel_i[0]) ctrl <= bus.data_i[4:0];
         if (bus.waddr_i == ADDR_BAUD) begin
            if (bus.sel_i[0]) div[7:0]  <= bus.data_i[7:0];
            if (bus.sel_i[1]) div[15:8] <= bus.data_i[15:8];
         end
      end
   end

   // Sticky error flags; the hardware set is applied after the clear so it wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         if (w1c_c) begin
            if (bus.data_i[3]) overrun <= 1'b0;
            if (bus.data_i[4]) par_err <= 1'b0;
            if (bus.data_i[5]) frm_err <= 1'b0;
         end
         if (rx_done_c) begin
            if (rx_full)   overrun <= 1'b1;
            if (par_bad_c) par_err <= 1'b1;
            if (!rx_s2)    frm_err <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata_c = '0;
      case (bus.raddr_i)
         ADDR_CTRL:   rdata_c = {27'd0, ctrl};
         ADDR_STATUS: rdata_c = {26'd0, frm_err, par_err, overrun, tx_full, !rx_empty, tx_busy};
         ADDR_BAUD:   rdata_c = {16'd0, div};
         ADDR_RXDATA: rdata_c = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
         ADDR_LEVEL:  rdata_c = {16'd0, 8'(rx_cnt), 8'(tx_cnt)};
         default:     rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        bus.data_o <= '0;
      else if (bus.rd_i) bus.data_o <= rdata_c;
   end

   // FIFO pointers and counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push_c) tx_wp <= tx_wp + AW'(1);
         if (tx_pop_c)  tx_rp <= tx_rp + AW'(1);
         tx_cnt <= tx_cnt + CW'(tx_push_c) - CW'(tx_pop_c);
         if (rx_push_c) rx_wp <= rx_wp + AW'(1);
         if (rx_pop_c)  rx_rp <= rx_rp + AW'(1);
         rx_cnt <= rx_cnt + CW'(rx_push_c) - CW'(rx_pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem[tx_wp] <= bus.data_i[7:0];
      if (rx_push_c) rx_mem[rx_wp] <= rx_shift;
   end

   // TX framer; bit period reloads from div so BAUD writes take effect per bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state   <= S_IDLE;
         tx_pin     <= 1'b1;
         tx_bcnt    <= '0;
         tx_bit     <= '0;
         tx_data    <= '0;
         tx_stop2nd <= 1'b0;
      end else begin
         if (tx_state != S_IDLE && tx_bcnt != 16'd0) tx_bcnt <= tx_bcnt - 16'd1;
         case (tx_state)
            S_IDLE: begin
               tx_pin <= 1'b1;
               if (tx_pop_c) begin
                  tx_data  <= tx_mem[tx_rp];
                  tx_state <= S_START;
                  tx_pin   <= 1'b0;
                  tx_bcnt  <= div;
               end
            end
            S_START: if (tx_bcnt == 16'd0) begin
               tx_state <= S_DATA;
               tx_pin   <= tx_data[0];
               tx_bit   <= 3'd0;
               tx_bcnt  <= div;
            end
            S_DATA: if (tx_bcnt == 16'd0) begin
               tx_bcnt <= div;
               if (tx_bit == 3'd7) begin
                  tx_stop2nd <= 1'b0;
                  if (par_en) begin
                     tx_state <= S_PARITY;
                     tx_pin   <= ^tx_data ^ par_odd;
                  end else begin
                     tx_state <= S_STOP;
                     tx_pin   <= 1'b1;
                  end
               end else begin
                  tx_bit <= tx_bit + 3'd1;
                  tx_pin <= tx_data[tx_bit + 3'd1];
               end
            end
            S_PARITY: if (tx_bcnt == 16'd0) begin
               tx_state <= S_STOP;
               tx_pin   <= 1'b1;
               tx_bcnt  <= div;
            end
            S_STOP: if (tx_bcnt == 16'd0) begin
               if (stop2 && !tx_stop2nd) begin
                  tx_stop2nd <= 1'b1;
                  tx_bcnt    <= div;
               end else begin
                  tx_state <= S_IDLE;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   // rx_pin synchroniser plus one extra stage for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_pin;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // RX deframer; clearing rx_en abandons the frame immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= S_IDLE;
         rx_bcnt  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_par   <= 1'b0;
      end else if (!rx_en) begin
         rx_state <= S_IDLE;
      end else begin
         if (rx_state != S_IDLE && rx_bcnt != 16'd0) rx_bcnt <= rx_bcnt - 16'd1;
         case (rx_state)
            S_IDLE: if (rx_prev && !rx_s2) begin
               rx_state <= S_START;
               rx_bcnt  <= half_m1_c;
            end
            S_START: if (rx_bcnt == 16'd0) begin
               if (rx_s2) begin
                  rx_state <= S_IDLE;
               end else begin
                  rx_state <= S_DATA;
                  rx_bit   <= 3'd0;
                  rx_bcnt  <= div;
               end
            end
            S_DATA: if (rx_bcnt == 16'd0) begin
               rx_shift <= {rx_s2, rx_shift[7:1]};
               rx_bcnt  <= div;
               if (rx_bit == 3'd7) rx_state <= par_en ? S_PARITY : S_STOP;
               else                rx_bit   <= rx_bit + 3'd1;
            end
            S_PARITY: if (rx_bcnt == 16'd0) begin
               rx_par   <= rx_s2;
               rx_state <= S_STOP;
               rx_bcnt  <= div;
            end
            S_STOP: if (rx_bcnt == 16'd0) rx_state <= S_IDLE;
            default: rx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: register vector table plus serial TX/RX sequences.
module tb_uart_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_pin = 1'b1;
   logic tx_pin;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   uart_fifo_if bus ();

   uart_fifo #(.CLK_HZ(50000000), .BAUD_DEF(115200), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .tx_pin(tx_pin), .rx_pin(rx_pin)
   );

   typedef struct {
      logic        do_wr;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wsel;
      logic [7:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.waddr_i = a;
      bus.data_i  = d;
      bus.sel_i   = s;
      bus.we_i    = 1'b1;
      step(1);
      bus.we_i    = 1'b0;
   endtask

   task automatic rdchk(input string name, input logic [7:0] a, input logic [31:0] exp);
      bus.raddr_i = a;
      bus.rd_i    = 1'b1;
      step(1);
      bus.rd_i    = 1'b0;
      chk(name, bus.data_o, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
      chk("rst_data_o", bus.data_o, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   // Drive one RX frame with 4-cycle bits (div=3)
   task automatic send_rx(input logic [7:0] b, input bit has_par, input logic pbit, input logic stopv);
      rx_pin = 1'b0;
      step(4);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         step(4);
      end
      if (has_par) begin
         rx_pin = pbit;
         step(4);
      end
      rx_pin = stopv;
      step(4);
      rx_pin = 1'b1;
      step(4);
   endtask

   // Wait for a start bit and check every cycle of the frame against the expected levels
   task automatic check_frame(input logic [7:0] b, input bit pe, input bit po, input bit s2);
      logic lv [$];
      int   t;
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(b[i]);
      if (pe) lv.push_back(^b ^ po);
      lv.push_back(1'b1);
      if (s2) lv.push_back(1'b1);
      t = 0;
      while (tx_pin !== 1'b0 && t < 300) begin
         step(1);
         t++;
      end
      chk($sformatf("tx_%02h_start_seen", b), {31'd0, tx_pin}, 32'd0);
      if (tx_pin !== 1'b0) return;
      for (int idx = 0; idx < lv.size(); idx++) begin
         for (int c = 0; c < 4; c++) begin
            if (idx != 0 || c != 0) step(1);
            chk($sformatf("tx_%02h_bit%0d_c%0d", b, idx, c), {31'd0, tx_pin}, {31'd0, lv[idx]});
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      bus.waddr_i = '0;
      bus.data_i  = '0;
      bus.sel_i   = '0;
      bus.we_i    = 1'b0;
      bus.raddr_i = '0;
      bus.rd_i    = 1'b0;

      vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h00, 32'h0000_0000};
      vecs[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h04, 32'h0000_0000};
      vecs[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h08, 32'h0000_01B1};
      vecs[3]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h14, 32'h0000_0000};
      vecs[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h10, 32'h0000_0000};
      vecs[5]  = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h20, 32'h0000_0000};
      vecs[6]  = '{1'b1, 8'h00, 32'hFFFF_FFFE, 4'h1, 8'h00, 32'h0000_001E};
      vecs[7]  = '{1'b1, 8'h00, 32'h0000_001F, 4'h0, 8'h00, 32'h0000_001E};
      vecs[8]  = '{1'b1, 8'h08, 32'h0000_1234, 4'h1, 8'h08, 32'h0000_0134};
      vecs[9]  = '{1'b1, 8'h08, 32'h0000_5600, 4'h2, 8'h08, 32'h0000_5634};
      vecs[10] = '{1'b1, 8'h08, 32'hFFFF_0003, 4'hF, 8'h08, 32'h0000_0003};
      vecs[11] = '{1'b1, 8'h00, 32'h0000_0000, 4'h1, 8'h00, 32'h0000_0000};
      vecs[12] = '{1'b1, 8'h0C, 32'h0000_0011, 4'h0, 8'h14, 32'h0000_0000};
      vecs[13] = '{1'b1, 8'h0C, 32'h0000_0022, 4'h1, 8'h14, 32'h0000_0001};
      vecs[14] = '{1'b0, 8'h00, 32'h0,        4'h0, 8'h04, 32'h0000_0001};

      step(1);
      do_reset();
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wsel);
         rdchk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      end
      step(3);
      chk("data_o_hold", bus.data_o, 32'h0000_0001);

      // 0xA5, 8N1, div=3
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h01, 4'h1);
      wr(8'h0C, 32'hA5, 4'h1);
      check_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      step(3);
      rdchk("a5_status_idle", 8'h04, 32'h0);

      // 0x03 with odd parity (bit = 1) and two stop bits
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h1D, 4'h1);
      wr(8'h0C, 32'h03, 4'h1);
      check_frame(8'h03, 1'b1, 1'b1, 1'b1);
      step(3);
      rdchk("par_status_idle", 8'h04, 32'h0);

      // RX 0x5A
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h02, 4'h1);
      send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
      rdchk("rx_status_nempty", 8'h04, 32'h02);
      rdchk("rx_level_1", 8'h14, 32'h0100);
      rdchk("rx_data_5a", 8'h10, 32'h5A);
      rdchk("rx_level_0", 8'h14, 32'h0000);
      rdchk("rx_read_empty", 8'h10, 32'h0);

      // 9 frames into an 8-deep RX FIFO
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h02, 4'h1);
      for (int i = 0; i < 9; i++) send_rx(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      rdchk("ovr_level", 8'h14, 32'h0800);
      rdchk("ovr_status", 8'h04, 32'h0A);
      for (int i = 0; i < 8; i++) rdchk($sformatf("ovr_data%0d", i), 8'h10, 32'(8'h10 + i));
      rdchk("ovr_level_0", 8'h14, 32'h0);
      wr(8'h04, 32'h08, 4'h1);
      rdchk("ovr_w1c", 8'h04, 32'h0);

      // False start, framing error, parity error
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h02, 4'h1);
      rx_pin = 1'b0;
      step(1);
      rx_pin = 1'b1;
      step(30);
      rdchk("glitch_level", 8'h14, 32'h0);
      rdchk("glitch_status", 8'h04, 32'h0);
      send_rx(8'h3C, 1'b0, 1'b0, 1'b0);
      rdchk("frm_status", 8'h04, 32'h22);
      rdchk("frm_level", 8'h14, 32'h0100);
      wr(8'h04, 32'h20, 4'h1);
      rdchk("frm_w1c", 8'h04, 32'h02);
      rdchk("frm_data", 8'h10, 32'h3C);
      wr(8'h00, 32'h06, 4'h1);
      send_rx(8'h01, 1'b1, 1'b0, 1'b1);
      rdchk("par_err_status", 8'h04, 32'h12);
      rdchk("par_err_data", 8'h10, 32'h01);

      // TX FIFO fill with tx_en=0, then drain
      do_reset();
      wr(8'h08, 32'd3, 4'h3);
      for (int i = 0; i < 9; i++) wr(8'h0C, 32'(8'h40 + i), 4'h1);
      rdchk("txfull_status", 8'h04, 32'h05);
      rdchk("txfull_level", 8'h14, 32'h0008);
      wr(8'h00, 32'h01, 4'h1);
      for (int i = 0; i < 8; i++) check_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      lows = 0;
      repeat (100) begin
         step(1);
         if (tx_pin !== 1'b1) lows++;
      end
      chk("tx_no_9th_frame", 32'(lows), 32'd0);
      rdchk("txdrain_level", 8'h14, 32'h0);
      rdchk("txdrain_status", 8'h04, 32'h0);

      // Reset in the middle of a low data bit
      wr(8'h0C, 32'h00, 4'h1);
      step(8);
      chk("mid_frame_low", {31'd0, tx_pin}, 32'd0);
      do_reset();
      lows = 0;
      repeat (60) begin
         step(1);
         if (tx_pin !== 1'b1) lows++;
      end
      chk("post_reset_idle", 32'(lows), 32'd0);
      rdchk("post_reset_level", 8'h14, 32'h0);
      rdchk("post_reset_baud", 8'h08, 32'h01B1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_DEF, default 115200: baud rate in effect after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port waddr_i  input  8  register write byte offset.
REQ-007 SHALL have port data_i  input  32  write data.
REQ-008 SHALL have port sel_i  input  4  byte-lane write enables.
REQ-009 SHALL have port we_i  input  1  write strobe; one write per cycle.
REQ-010 SHALL have port raddr_i  input  8  register read byte offset.
REQ-011 SHALL have port rd_i  input  1  read strobe.
REQ-012 SHALL have port data_o  output  32  read data, registered.
REQ-013 SHALL have port tx_pin  output  1  serial output; idle high.
REQ-014 SHALL have port rx_pin  input  1  serial input; asynchronous to clk.

Function
REQ-015 SHALL decode registers at these offsets:
- 0x00 CTRL (RW): [0] tx_en, [1] rx_en, [2] par_en, [3] par_odd, [4] stop2.
- 0x04 STATUS: [0] tx_busy (RO), [1] rx_nempty (RO), [2] tx_full (RO), [3] overrun (W1C), [4] par_err (W1C), [5] frm_err (W1C).
- 0x08 BAUD (RW): [15:0] div.
- 0x0C TXDATA (WO): [7:0] push to TX FIFO.
- 0x10 RXDATA (RO): [7:0] pop from RX FIFO.
- 0x14 LEVEL (RO): [15:8] RX count, [7:0] TX count.
REQ-016 SHALL apply writes only on byte lanes with sel_i set: CTRL/STATUS/TXDATA use lane 0; BAUD uses lanes 0-1.
REQ-017 SHALL present read data on data_o the cycle after rd_i; data_o SHALL hold when rd_i=0; unmapped offsets read 0.
REQ-018 SHALL pop the RX FIFO on an RXDATA read when not empty; a read while empty returns 0 with no pop.
REQ-019 SHALL drop a TXDATA write while the TX FIFO is full, with no other effect.
REQ-020 SHALL make one bit period div+1 clk cycles for both TX and RX.
REQ-021 SHALL use TX FSM states IDLE -> START -> DATA(8 bits, LSB first) -> PARITY (only if par_en) -> STOP (1 bit, or 2 if stop2) -> IDLE.
REQ-022 SHALL leave IDLE only when tx_en=1 and the TX FIFO is not empty, popping one byte on the exit cycle.
REQ-023 SHALL send a parity bit equal to XOR of the data bits when par_odd=0, and its inverse when par_odd=1.
REQ-024 SHALL finish an in-progress frame when tx_en is cleared mid-frame, then stay in IDLE; FIFO contents SHALL be kept.
REQ-025 SHALL set tx_busy = (TX FSM != IDLE) or (TX FIFO not empty).
REQ-026 SHALL pass rx_pin through a 2-flop synchroniser; RX logic SHALL use only the synchronised value.
REQ-027 SHALL use RX FSM states IDLE -> START -> DATA -> PARITY (if par_en) -> STOP -> IDLE.
REQ-028 SHALL leave RX IDLE on a detected falling edge while rx_en=1.
REQ-029 SHALL sample each RX bit (div+1)/2 cycles (integer division) into its bit period.
REQ-030 SHALL treat a start bit sampled high as a false start: return to IDLE, push nothing, set no flag.
REQ-031 SHALL check only the first stop bit on RX; stop2 affects TX only.
REQ-032 SHALL, at the stop-bit sample, push the byte to the RX FIFO (or drop it and set overrun if full), set par_err on parity mismatch, and set frm_err if the stop bit is 0; the byte SHALL be pushed despite these errors.
REQ-033 SHALL return RX to IDLE at once when rx_en is cleared, with no push; FIFO contents SHALL be kept.
REQ-034 SHALL give a hardware set priority over a W1C clear in the same cycle.
REQ-035 SHALL handle a simultaneous push and pop on either FIFO without changing its count; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 SHALL apply a BAUD write mid-frame from the next bit-counter reload.

Reset
REQ-037 SHALL, while rst_n=0, set CTRL=0, STATUS flags=0, both FIFOs empty, both FSMs IDLE, tx_pin=1, data_o=0, and div=CLK_HZ/BAUD_DEF-1.
REQ-038 SHALL abort any frame in progress on reset without emitting a glitch low on tx_pin.

Verification
REQ-039 SHALL cover: div=3, CTRL=0x01, push 0xA5 -> tx_pin low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; tx_busy clears after.
REQ-040 SHALL cover: CTRL=0x1D (par_en, par_odd, stop2), push 0x03 -> parity bit 1, stop high 8 cycles.
REQ-041 SHALL cover: rx_en=1, div=3, drive 0x5A frame on rx_pin -> rx_nempty=1, RXDATA read returns 0x5A, LEVEL[15:8] goes 1 -> 0.
REQ-042 SHALL cover: FIFO_DEPTH=8, send 9 frames with no reads -> LEVEL[15:8]=8, overrun=1, first 8 bytes read back in order.
REQ-043 SHALL cover: rx_pin low for only 1 cycle -> no push, no flags; stop bit driven 0 -> byte pushed, frm_err=1; W1C 0x20 -> frm_err=0.
REQ-044 SHALL cover: 9 TXDATA writes with tx_en=0 -> tx_full=1, TX count 8; then tx_en=1 -> 8 frames sent and the 9th byte is never sent.
